// File: rtl/frame_sched.sv
// Sequencing controller for the 1x20 -> 1x5 window fetcher.
// Gates frame loads, tags the 6-window burst for the compute stage, and counts frames per utterance.
module frame_sched #(
  parameter int WIN_PER_FRAME  = 6,
  parameter int FRAMES_PER_UTT = 100,
  parameter int FCNT_W         = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic              frame_valid,
  output logic              frame_ready,
  input  logic              fetch_empty,
  output logic              fetch_rd_en,
  input  logic              cmp_ready,
  output logic              win_valid,
  output logic [2:0]        win_idx,
  output logic              win_first,
  output logic              win_last,
  output logic [FCNT_W-1:0] frame_idx,
  output logic              busy,
  output logic              utt_done,
  output logic              err
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WAIT   = 3'd1,
    S_LOAD   = 3'd2,
    S_STREAM = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic              w_fire;
  logic              w_last_win;
  logic              w_last_frame;
  logic              w_start_ok;
  logic              w_err_set;
  logic [2:0]        w_next_idx;
  logic [2:0]        r_win_idx;
  logic              r_win_valid;
  logic              r_win_first;
  logic              r_win_last;
  logic [FCNT_W-1:0] r_frame_idx;
  logic              r_busy;
  logic              r_utt_done;
  logic              r_err;

  assign w_fire       = (r_state == S_WAIT) && frame_valid && fetch_empty && cmp_ready;
  assign w_last_win   = (r_win_idx == 3'(WIN_PER_FRAME - 1));
  assign w_last_frame = (r_frame_idx == FCNT_W'(FRAMES_PER_UTT - 1));
  assign w_start_ok   = (r_state == S_IDLE) && start && !abort;
  // The fetcher's output register holds the burst, so an empty flag mid-burst means it lost sync.
  assign w_err_set    = (fetch_empty && (r_state == S_LOAD)) ||
                        (fetch_empty && (r_state == S_STREAM) && !w_last_win);

  // Next-state decode; abort overrides every transition.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) w_next = S_WAIT;
        else       w_next = S_IDLE;
      end
      S_WAIT: begin
        if (w_fire) w_next = S_LOAD;
        else        w_next = S_WAIT;
      end
      S_LOAD:   w_next = S_STREAM;
      S_STREAM: begin
        if (w_last_win) w_next = w_last_frame ? S_DONE : S_WAIT;
        else            w_next = S_STREAM;
      end
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
    if (abort) w_next = S_IDLE;
    else       w_next = w_next;
  end

  // Window index for the coming cycle: counts only while staying in STREAM.
  always_comb begin
    w_next_idx = 3'd0;
    if ((r_state == S_STREAM) && (w_next == S_STREAM)) w_next_idx = r_win_idx + 3'd1;
    else                                                w_next_idx = 3'd0;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Registered window tags and status flags, all derived from the upcoming state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_win_valid <= 1'b0;
      r_win_idx   <= 3'd0;
      r_win_first <= 1'b0;
      r_win_last  <= 1'b0;
      r_busy      <= 1'b0;
      r_utt_done  <= 1'b0;
    end else begin
      r_win_valid <= (w_next == S_STREAM);
      r_win_idx   <= w_next_idx;
      r_win_first <= (w_next == S_STREAM) && (w_next_idx == 3'd0);
      r_win_last  <= (w_next == S_STREAM) && (w_next_idx == 3'(WIN_PER_FRAME - 1));
      r_busy      <= (w_next != S_IDLE);
      r_utt_done  <= (w_next == S_DONE);
    end
  end

  // Frame counter: cleared by an accepted start, advanced after each non-final burst.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_idx <= '0;
    end else if (w_start_ok) begin
      r_frame_idx <= '0;
    end else if ((r_state == S_STREAM) && w_last_win && !w_last_frame && !abort) begin
      r_frame_idx <= r_frame_idx + FCNT_W'(1);
    end else begin
      r_frame_idx <= r_frame_idx;
    end
  end

  // Sticky protocol error, cleared only by an accepted start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          r_err <= 1'b0;
    else if (w_start_ok) r_err <= 1'b0;
    else if (w_err_set)  r_err <= 1'b1;
    else                 r_err <= r_err;
  end

  assign frame_ready = w_fire;
  assign fetch_rd_en = w_fire;
  assign win_valid   = r_win_valid;
  assign win_idx     = r_win_idx;
  assign win_first   = r_win_first;
  assign win_last    = r_win_last;
  assign frame_idx   = r_frame_idx;
  assign busy        = r_busy;
  assign utt_done    = r_utt_done;
  assign err         = r_err;

endmodule
